// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : demux_pkg
// Purpose  : Shared constants for the 1-to-4 stream demultiplexer.
// Contents : NUM_CH  - number of output channels
//            SEL_W   - width of a channel index / round-robin pointer
//            RR_WRAP - last pointer value before wrapping back to 0
// Revision : 1.0 - initial release
// ============================================================================
package demux_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;
  localparam logic [SEL_W-1:0] RR_WRAP = SEL_W'(NUM_CH - 1);

endpackage : demux_pkg
`default_nettype wire

// File: rtl/demux1_4_stream_if.sv
`default_nettype none
// ============================================================================
// Module   : demux1_4_stream_if
// Purpose  : Bundles the producer-side stream, the four consumer channels and
//            the status outputs of demux1_4_stream.
// Ports    : in_valid/in_ready/in_data/in_sel/rr_en - producer side
//            y0..y3/y_valid/y_ready                  - consumer channels
//            rr_ptr/busy                             - status
// Modports : master - environment (drives producer side and y_ready)
//            slave  - the demultiplexer itself
// Revision : 1.0 - initial release
// ============================================================================
interface demux1_4_stream_if #(
  parameter int WIDTH = 3
);
  import demux_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_data;
  logic [SEL_W-1:0]     in_sel;
  logic                 rr_en;
  logic [WIDTH-1:0]     y0;
  logic [WIDTH-1:0]     y1;
  logic [WIDTH-1:0]     y2;
  logic [WIDTH-1:0]     y3;
  logic [NUM_CH-1:0]    y_valid;
  logic [NUM_CH-1:0]    y_ready;
  logic [SEL_W-1:0]     rr_ptr;
  logic                 busy;

  modport master (
    output in_valid, in_data, in_sel, rr_en, y_ready,
    input  in_ready, y0, y1, y2, y3, y_valid, rr_ptr, busy
  );

  modport slave (
    input  in_valid, in_data, in_sel, rr_en, y_ready,
    output in_ready, y0, y1, y2, y3, y_valid, rr_ptr, busy
  );

endinterface : demux1_4_stream_if
`default_nettype wire

// File: rtl/demux_slot.sv
`default_nettype none
// ============================================================================
// Module   : demux_slot
// Purpose  : One-entry holding register for a single output channel.
//            A load always wins over a drain, so a channel that is emptied
//            and refilled in the same cycle stays valid with the new word.
//            Data is kept when the slot drains (content is stale but stable).
// Ports    : clk   - clock
//            rst_n - asynchronous active-low reset
//            load  - capture din this cycle
//            din   - incoming word
//            ready - consumer takes the held word this cycle
//            dout  - held word
//            valid - slot holds a valid word
// Revision : 1.0 - initial release
// ============================================================================
module demux_slot #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic [WIDTH-1:0] dout,
  output logic             valid
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic             valid_q;
  logic             valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (load) begin
      data_d  = din;
      valid_d = 1'b1;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign dout  = data_q;
  assign valid = valid_q;

endmodule : demux_slot
`default_nettype wire

// File: rtl/demux1_4_stream.sv
`default_nettype none
// ============================================================================
// Module   : demux1_4_stream
// Purpose  : Registered 1-to-4 stream demultiplexer. Each accepted word is
//            steered to one of four one-entry channel slots, chosen either by
//            an explicit select or by a strict-order round-robin pointer.
// Ports    : clk   - clock
//            rst_n - asynchronous active-low reset
//            bus   - demux1_4_stream_if.slave (stream in, channels out,
//                    rr_ptr and busy status)
// Revision : 1.0 - initial release
// ============================================================================
module demux1_4_stream
  import demux_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  demux1_4_stream_if.slave    bus
);

  logic [SEL_W-1:0]  dest;
  logic              in_ready;
  logic              accept;
  logic [NUM_CH-1:0] y_valid;
  logic [WIDTH-1:0]  y_data [NUM_CH];
  logic [SEL_W-1:0]  rr_ptr_q;
  logic [SEL_W-1:0]  rr_ptr_d;

  // Destination follows rr_en in the same cycle; the pointer value itself is
  // untouched by mode changes.
  assign dest = bus.rr_en ? rr_ptr_q : bus.in_sel;

  // Only the addressed channel matters: a full slot accepts when its own
  // consumer is draining it this cycle. No dependency on in_valid.
  assign in_ready = ~y_valid[dest] | bus.y_ready[dest];
  assign accept   = bus.in_valid & in_ready;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
    demux_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (accept && (dest == SEL_W'(i))),
      .din   (bus.in_data),
      .ready (bus.y_ready[i]),
      .dout  (y_data[i]),
      .valid (y_valid[i])
    );
  end

  // Pointer never skips a busy channel: it only moves on an actual accept.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept && bus.rr_en) begin
      rr_ptr_d = (rr_ptr_q == RR_WRAP) ? '0 : rr_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.y0       = y_data[0];
  assign bus.y1       = y_data[1];
  assign bus.y2       = y_data[2];
  assign bus.y3       = y_data[3];
  assign bus.y_valid  = y_valid;
  assign bus.rr_ptr   = rr_ptr_q;
  assign bus.busy     = |y_valid;

endmodule : demux1_4_stream
`default_nettype wire

// File: tb/tb_demux1_4_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux1_4_stream
// Purpose  : Self-checking bench for demux1_4_stream. A directed vector table
//            walks explicit select, drain+refill, round-robin, round-robin
//            stall and mode switching; an asynchronous mid-cycle reset is
//            applied by hand; then random traffic runs against a queue-free
//            array model of the four channel slots and the pointer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_demux1_4_stream;

  logic clk;
  logic rst_n;

  demux1_4_stream_if #(.WIDTH(3)) bus ();

  demux1_4_stream #(.WIDTH(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // Reference model: channel contents, valid flags and pointer.
  logic [2:0] m_dat [4];
  logic       m_val [4];
  int         m_ptr;

  typedef struct {
    logic       v;
    logic [2:0] d;
    logic [1:0] s;
    logic       rr;
    logic [3:0] yr;
    logic       exp_rdy;
    logic [3:0] exp_yv;
    logic [1:0] exp_ptr;
    int         ch;
    logic [2:0] exp_y;
  } vec_t;

  vec_t tbl [21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] y_of(input int c);
    case (c)
      0:       return bus.y0;
      1:       return bus.y1;
      2:       return bus.y2;
      default: return bus.y3;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_dat[i] = '0;
      m_val[i] = 1'b0;
    end
    m_ptr = 0;
  endtask

  task automatic check_all();
    logic [3:0] yv;
    int         any;
    any = 0;
    for (int i = 0; i < 4; i++) begin
      yv[i] = m_val[i];
      if (m_val[i]) any = 1;
      chk($sformatf("y%0d", i), 32'(y_of(i)), 32'(m_dat[i]));
    end
    chk("y_valid", 32'(bus.y_valid), 32'(yv));
    chk("rr_ptr", 32'(bus.rr_ptr), 32'(m_ptr));
    chk("busy", 32'(bus.busy), 32'(any));
  endtask

  // One cycle: drive, check the combinational ready, clock, advance model,
  // check registered outputs.
  task automatic step(input logic v, input logic [2:0] d, input logic [1:0] s,
                      input logic rr, input logic [3:0] yr, output logic rdy);
    int   dst;
    logic m_rdy;
    logic acc;
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_sel   = s;
    bus.rr_en    = rr;
    bus.y_ready  = yr;
    #1;
    dst   = rr ? m_ptr : int'(s);
    m_rdy = !m_val[dst] || yr[dst];
    chk("in_ready", 32'(bus.in_ready), 32'(m_rdy));
    rdy = bus.in_ready;
    @(posedge clk);
    acc = v && m_rdy;
    for (int i = 0; i < 4; i++) begin
      if (acc && dst == i) begin
        m_dat[i] = d;
        m_val[i] = 1'b1;
      end else if (m_val[i] && yr[i]) begin
        m_val[i] = 1'b0;
      end
    end
    if (acc && rr) m_ptr = (m_ptr + 1) % 4;
    #1;
    check_all();
  endtask

  logic r;

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_sel   = '0;
    bus.rr_en    = 1'b0;
    bus.y_ready  = '0;
    model_reset();

    //          v    d     s     rr   yr        rdy  yv        ptr  ch y
    tbl[0]  = '{1'b1, 3'd5, 2'd2, 1'b0, 4'b0000, 1'b1, 4'b0100, 2'd0, 2, 3'd5};
    tbl[1]  = '{1'b1, 3'd6, 2'd2, 1'b0, 4'b0000, 1'b0, 4'b0100, 2'd0, 2, 3'd5};
    tbl[2]  = '{1'b1, 3'd3, 2'd1, 1'b0, 4'b0000, 1'b1, 4'b0110, 2'd0, 1, 3'd3};
    tbl[3]  = '{1'b1, 3'd7, 2'd2, 1'b0, 4'b0100, 1'b1, 4'b0110, 2'd0, 2, 3'd7};
    tbl[4]  = '{1'b0, 3'd0, 2'd2, 1'b0, 4'b0100, 1'b1, 4'b0010, 2'd0, 2, 3'd7};
    tbl[5]  = '{1'b0, 3'd0, 2'd1, 1'b0, 4'b0010, 1'b1, 4'b0000, 2'd0, 1, 3'd3};
    tbl[6]  = '{1'b1, 3'd1, 2'd3, 1'b1, 4'b1111, 1'b1, 4'b0001, 2'd1, 0, 3'd1};
    tbl[7]  = '{1'b1, 3'd2, 2'd3, 1'b1, 4'b1111, 1'b1, 4'b0010, 2'd2, 1, 3'd2};
    tbl[8]  = '{1'b1, 3'd3, 2'd0, 1'b1, 4'b1111, 1'b1, 4'b0100, 2'd3, 2, 3'd3};
    tbl[9]  = '{1'b1, 3'd4, 2'd0, 1'b1, 4'b1111, 1'b1, 4'b1000, 2'd0, 3, 3'd4};
    tbl[10] = '{1'b1, 3'd5, 2'd2, 1'b1, 4'b1111, 1'b1, 4'b0001, 2'd1, 0, 3'd5};
    tbl[11] = '{1'b0, 3'd0, 2'd0, 1'b1, 4'b1111, 1'b1, 4'b0000, 2'd1, 0, 3'd5};
    tbl[12] = '{1'b1, 3'd6, 2'd1, 1'b0, 4'b0000, 1'b1, 4'b0010, 2'd1, 1, 3'd6};
    tbl[13] = '{1'b1, 3'd2, 2'd0, 1'b1, 4'b0000, 1'b0, 4'b0010, 2'd1, 1, 3'd6};
    tbl[14] = '{1'b1, 3'd2, 2'd0, 1'b1, 4'b0000, 1'b0, 4'b0010, 2'd1, 1, 3'd6};
    tbl[15] = '{1'b1, 3'd2, 2'd0, 1'b1, 4'b0000, 1'b0, 4'b0010, 2'd1, 1, 3'd6};
    tbl[16] = '{1'b1, 3'd2, 2'd0, 1'b1, 4'b0010, 1'b1, 4'b0010, 2'd2, 1, 3'd2};
    tbl[17] = '{1'b1, 3'd1, 2'd0, 1'b1, 4'b0000, 1'b1, 4'b0110, 2'd3, 2, 3'd1};
    tbl[18] = '{1'b1, 3'd4, 2'd0, 1'b0, 4'b0000, 1'b1, 4'b0111, 2'd3, 0, 3'd4};
    tbl[19] = '{1'b1, 3'd5, 2'd0, 1'b0, 4'b0001, 1'b1, 4'b0111, 2'd3, 0, 3'd5};
    tbl[20] = '{1'b1, 3'd7, 2'd1, 1'b1, 4'b0000, 1'b1, 4'b1111, 2'd0, 3, 3'd7};

    // Reset state while held in reset across edges.
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed table.
    for (int k = 0; k < 21; k++) begin
      step(tbl[k].v, tbl[k].d, tbl[k].s, tbl[k].rr, tbl[k].yr, r);
      chk($sformatf("tbl%0d.in_ready", k), 32'(r), 32'(tbl[k].exp_rdy));
      chk($sformatf("tbl%0d.y_valid", k), 32'(bus.y_valid), 32'(tbl[k].exp_yv));
      chk($sformatf("tbl%0d.rr_ptr", k), 32'(bus.rr_ptr), 32'(tbl[k].exp_ptr));
      chk($sformatf("tbl%0d.y%0d", k, tbl[k].ch), 32'(y_of(tbl[k].ch)), 32'(tbl[k].exp_y));
    end

    // Drain channels 0 and 2 to leave y_valid = 1010, then reset mid-cycle.
    step(1'b0, 3'd0, 2'd0, 1'b0, 4'b0101, r);
    chk("pre_reset.y_valid", 32'(bus.y_valid), 32'h0000000a);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("async_reset.y_valid", 32'(bus.y_valid), 32'h0);
    chk("async_reset.y3", 32'(bus.y3), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all();

    // Random traffic against the model.
    for (int k = 0; k < 600; k++) begin
      step(1'($urandom_range(0, 3) != 0), 3'($urandom), 2'($urandom),
           1'($urandom_range(0, 1)), 4'($urandom), r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_demux1_4_stream
`default_nettype wire

// File: doc/demux1_4_stream.md
Name: demux1_4_stream

Overview:
- Registered 1-to-4 demultiplexer. It is the distributing counterpart of the team's 4:1 selector.
- Takes one valid/ready input stream and steers each word to one of four output channels y0..y3.
- The channel comes from an explicit 2-bit select, or from an internal round-robin pointer.
- Sits between a single producer and four consumers (e.g. display digits, per-lane registers). Each channel has a one-entry holding register so consumers can stall independently.

Parameters:
- WIDTH, 3, data width of the input word and of each output channel.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  producer has a word on in_data.
- in_ready  output  1  block can accept the word this cycle (combinational).
- in_data  input  WIDTH  word to distribute.
- in_sel  input  2  destination channel; used only when rr_en=0.
- rr_en  input  1  1 = destination is the internal round-robin pointer; 0 = in_sel.
- y0, y1, y2, y3  output  WIDTH each  channel data, registered.
- y_valid  output  4  bit i = channel i holds a valid word.
- y_ready  input  4  bit i = consumer i takes the word this cycle.
- rr_ptr  output  2  current round-robin pointer, registered.
- busy  output  1  OR of y_valid.

Behaviour:
- Reset (rst_n=0, asynchronous): y0..y3=0, y_valid=4'b0000, rr_ptr=0, busy=0. Release is synchronous to clk (reset is deasserted before the next edge).
- Route: dest = rr_en ? rr_ptr : in_sel, evaluated combinationally each cycle.
- in_ready = ~y_valid[dest] | y_ready[dest].
  - This is a pass-through of y_ready for the addressed channel only. There is no dependency on in_valid.
- Accept: acc = in_valid & in_ready. Only one channel can be loaded per cycle.
- Channel i update at each clk edge:
  - load_i = acc & (dest==i); drain_i = y_valid[i] & y_ready[i].
  - If load_i: y_i <= in_data, y_valid[i] <= 1. This applies even when drain_i is 1 in the same cycle (simultaneous drain and refill: valid stays 1, new data).
  - Else if drain_i: y_valid[i] <= 0. y_i holds its last value; its content is don't-care when invalid but must not change.
  - Else: hold.
- Latency: a word accepted at edge N appears on y_dest with y_valid set after edge N (one cycle).
- Stability: while y_valid[i]=1 and y_ready[i]=0, y_i is constant.
- Channel independence: a stalled channel i never blocks a transfer to channel j≠i.
- Round-robin pointer:
  - Advances by 1 on every acc while rr_en=1, wrapping 3->0 (2-bit modulo).
  - Holds when rr_en=0 or there is no accept.
  - rr_en toggling takes effect combinationally for the current cycle's dest; the pointer value is preserved across mode changes.
  - In rr mode, if the channel at rr_ptr is full and not draining, in_ready=0. The pointer does not skip busy channels; strict order is required.
- y_ready while y_valid=0 is ignored.
- in_sel is ignored when rr_en=1. in_data/in_sel are ignored when in_valid=0.
- Reset mid-operation: all held words are discarded and the pointer returns to 0. No partial transfer may be visible after reset.
- busy = |y_valid (from registers).

Decomposition:
- Shared package demux_pkg:
  - NUM_CH=4, SEL_W=2.
  - A RR_WRAP constant (NUM_CH-1).
- One natural sub-module: demux_slot.
  - Parameter WIDTH.
  - Ports clk, rst_n, load, din, ready, dout, valid.
  - Instantiated four times.
- Top-level contents: dest mux, in_ready, the pointer, and busy.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with y_valid=4'b1010 -> immediately y_valid=0, y0..y3=0, rr_ptr=0, busy=0, without waiting for a clk edge.
- Explicit select: rr_en=0, y_ready=4'b0000, send in_data=3'b101 with in_sel=2 -> next cycle y2=5, y_valid=4'b0100. A second word to in_sel=2 sees in_ready=0. A word 3'b011 to in_sel=1 is accepted in the same stall -> y1=3, y_valid=4'b0110.
- Drain+refill: channel 2 full with 5, y_ready[2]=1, in_valid=1, in_sel=2, in_data=7 -> in_ready=1; after the edge y2=7, y_valid[2]=1 with no bubble. With in_valid=0 the next cycle -> y_valid[2]=0, y2 stays 7.
- Round-robin: rr_en=1, y_ready=4'b1111, stream 1,2,3,4,5 on consecutive cycles -> words land on y0,y1,y2,y3,y0; rr_ptr sequence 0,1,2,3,0,1.
- RR stall order: rr_en=1, rr_ptr=1, channel 1 full, y_ready[1]=0 -> in_ready=0 and rr_ptr holds 1 for 3 cycles. Raise y_ready[1] -> next word goes to y1, then rr_ptr=2.
- Mode switch: rr_ptr=3, set rr_en=0, send two words with in_sel=0 -> rr_ptr stays 3. Set rr_en=1 -> next word goes to y3, then rr_ptr=0.
